// File: rtl/mdio_master.sv
// Clause-22 MDIO frame engine: serialises one register access per request onto MDC/MDIO.
// Optional turnaround check on reads is enabled by defining MDIO_TA_CHECK_EN.
module mdio_master #(
  parameter int MDC_HALF = 1250,
  parameter int PRE_LEN  = 32
) (
  input  logic        clock_50m,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic        phy_mdc,
  inout  wire         phy_mdio
);

  localparam int          NBITS     = PRE_LEN + 32;
  localparam int          PAD       = 32 - PRE_LEN;
  localparam logic [15:0] HALF_LAST = 16'(MDC_HALF - 1);
  localparam logic [5:0]  BIT_LAST  = 6'(NBITS - 1);
  localparam logic [5:0]  TA_BIT    = 6'(PRE_LEN + 14);
  localparam logic [5:0]  DATA_BIT  = 6'(PRE_LEN + 16);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] half_q, half_d;
  logic [5:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic        mdc_q, mdc_d;
  logic        oe_q, oe_d;
  logic        rw_q, rw_d;
  logic [63:0] sr_q, sr_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [63:0] frame_w;
`ifdef MDIO_TA_CHECK_EN
  localparam logic [5:0] TA2_BIT = 6'(PRE_LEN + 15);
  logic ta_q, ta_d;
  logic rd_err_q, rd_err_d;
`endif

  // Frame left-justified in the shift register so the preamble length only sets the shift amount.
  assign frame_w = {32'hFFFF_FFFF, 2'b01, (rw ? 2'b10 : 2'b01), phy_addr, reg_addr,
                    (rw ? 2'b11 : 2'b10), wr_data} << PAD;

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    sr_d      = sr_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
`ifdef MDIO_TA_CHECK_EN
    ta_d      = ta_q;
    rd_err_d  = rd_err_q;
`endif
    if (state_q == S_SHIFT) begin
      if (half_q == HALF_LAST) begin
        half_d  = '0;
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + 6'd1;
            sr_d  = {sr_q[62:0], 1'b0};
          end
        end
      end else begin
        half_d = half_q + 16'd1;
      end
      // Sample on the first system clock of each MDC high half.
      if (phase_q && (half_q == '0) && (bit_q >= DATA_BIT)) begin
        rx_d = {rx_q[14:0], phy_mdio};
      end
`ifdef MDIO_TA_CHECK_EN
      if (phase_q && (half_q == '0) && (bit_q == TA2_BIT)) begin
        ta_d = phy_mdio;
      end
      if ((state_d == S_DONE) && rw_q) begin
        rd_err_d  = ta_q;
        rd_data_d = ta_q ? 16'hFFFF : rx_q;
      end
`else
      if ((state_d == S_DONE) && rw_q) begin
        rd_data_d = rx_q;
      end
`endif
    end else begin
      state_d = S_IDLE;
      if (start) begin
        state_d = S_SHIFT;
        rw_d    = rw;
        half_d  = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        sr_d    = frame_w;
`ifdef MDIO_TA_CHECK_EN
        rd_err_d = 1'b0;
`endif
      end
    end
    mdc_d = (state_d == S_SHIFT) && phase_d;
    oe_d  = (state_d == S_SHIFT) && (!rw_d || (bit_d < TA_BIT));
  end

  always_ff @(posedge clock_50m or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      half_q    <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      mdc_q     <= 1'b0;
      oe_q      <= 1'b0;
      rw_q      <= 1'b0;
      sr_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      mdc_q     <= mdc_d;
      oe_q      <= oe_d;
      rw_q      <= rw_d;
      sr_q      <= sr_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef MDIO_TA_CHECK_EN
  always_ff @(posedge clock_50m or posedge reset) begin
    if (reset) begin
      ta_q     <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      ta_q     <= ta_d;
      rd_err_q <= rd_err_d;
    end
  end
  assign rd_err = rd_err_q;
`else
  assign rd_err = 1'b0;
`endif

  assign busy     = (state_q == S_SHIFT);
  assign done     = (state_q == S_DONE);
  assign rd_data  = rd_data_q;
  assign phy_mdc  = mdc_q;
  assign phy_mdio = oe_q ? sr_q[63] : 1'bz;

endmodule
